multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: IF/ID/EX/MEM/WB sequencing, control strobes and retired count.
// Latency: 2-5 cycles per instruction; outputs are combinational decodes of the current state.
// Backpressure: mem_ready stalls MEM only when MEM_WAIT_EN is defined, otherwise MEM is one cycle.
module multicycle_ctrl #(
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                ir_we,
  output logic                pc_we,
  output logic                ct_branch,
  output logic                ct_jump,
  output logic                reg_we,
  output logic                mem_re,
  output logic                mem_we,
  output logic                illegal,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          state,
  output logic [31:0]         retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  state_e      state_q, state_d;
  logic [5:0]  opc_q, opc_d;
  logic [5:0]  fn_q, fn_d;
  logic [31:0] retired_q, retired_d;
  logic [2:0]  alu_c;
  logic        id_legal;
  logic        mem_done;

  // R-type funct codes that the ALU understands
  function automatic logic fn_known(input logic [5:0] f);
    return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
  endfunction

  function automatic logic [2:0] fn_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // ID has to act before the latch closes, so legality is judged on the live fields
  assign id_legal = (opcode inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW}) &&
                    ((opcode != OP_R) || fn_known(funct));

`ifdef MEM_WAIT_EN
  // MEM completes only when the data memory reports ready
  assign mem_done = mem_ready;
  // Branch outcome is resolved in the datapath, not here
  logic unused_in;
  assign unused_in = alu_zero;
`else
  // MEM is always a single cycle; mem_ready has no meaning in this build
  assign mem_done = 1'b1;
  logic unused_in;
  assign unused_in = ^{alu_zero, mem_ready};
`endif

  // Next-state, decode latch and control strobes from state plus latched fields
  always_comb begin
    state_d   = S_IF;
    opc_d     = opc_q;
    fn_d      = fn_q;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    ct_branch = 1'b0;
    ct_jump   = 1'b0;
    reg_we    = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    illegal   = 1'b0;
    alu_c     = ALU_ADD;
    case (state_q)
      S_IF: begin
        ir_we   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        opc_d = opcode;
        fn_d  = funct;
        if (!id_legal) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
        end else if (opcode == OP_J) begin
          ct_jump = 1'b1;
          pc_we   = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (opc_q)
          OP_BEQ: begin
            ct_branch = 1'b1;
            pc_we     = 1'b1;
            alu_c     = ALU_SUB;
          end
          OP_R: begin
            alu_c   = fn_alu(fn_q);
            state_d = S_WB;
          end
          OP_ADDI:      state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_IF;
        endcase
      end
      S_MEM: begin
        mem_re = (opc_q == OP_LW);
        mem_we = (opc_q == OP_SW);
        if (!mem_done) begin
          state_d = S_MEM;
        end else if (opc_q == OP_LW) begin
          state_d = S_WB;
        end else begin
          pc_we = 1'b1;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
      end
      default: state_d = S_IF;
    endcase
    retired_d = retired_q + {31'd0, pc_we};
  end

  // State, latched instruction fields and retired counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      opc_q     <= 6'd0;
      fn_q      <= 6'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      fn_q      <= fn_d;
      retired_q <= retired_d;
    end
  end

  assign alu_op  = ALU_OP_W'(alu_c);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks every instruction class and checks each cycle.
// Latency: checks sample at the falling edge, inputs change at the falling edge.
// Backpressure: mem_ready stall sequence is exercised according to the MEM_WAIT_EN build.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero, mem_ready;
  logic        ir_we, pc_we, ct_branch, ct_jump, reg_we, mem_re, mem_we, illegal;
  logic [2:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_asrt = 0;
  int n_fail = 0;
  logic [31:0] exp_ret = 32'd0;

  // control vector: {ir_we,pc_we,ct_branch,ct_jump,reg_we,mem_re,mem_we,illegal}
  localparam logic [7:0] C_IF  = 8'h80;
  localparam logic [7:0] C_NO  = 8'h00;
  localparam logic [7:0] C_WB  = 8'h48;
  localparam logic [7:0] C_J   = 8'h50;
  localparam logic [7:0] C_BEQ = 8'h60;
  localparam logic [7:0] C_LWM = 8'h04;
  localparam logic [7:0] C_SWF = 8'h42;
  localparam logic [7:0] C_SWW = 8'h02;
  localparam logic [7:0] C_ILL = 8'h41;

  multicycle_ctrl #(.ALU_OP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .ct_branch(ct_branch), .ct_jump(ct_jump),
    .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .illegal(illegal),
    .alu_op(alu_op), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // check the current cycle (called at a falling edge), then advance one cycle
  task automatic cyc(input string tag, input logic [2:0] es, input logic [7:0] ec,
                     input logic [2:0] ea);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, es});
    chk({tag, ".ctl"}, {24'd0, ir_we, pc_we, ct_branch, ct_jump, reg_we, mem_re, mem_we, illegal},
        {24'd0, ec});
    chk({tag, ".alu"}, {29'd0, alu_op}, {29'd0, ea});
    @(posedge clk);
    @(negedge clk);
  endtask

  // R-type: funct is scrambled after ID to prove EX uses the latched copy
  task automatic do_r(input string tag, input logic [5:0] f, input logic [2:0] ea);
    opcode = 6'b000000;
    funct  = f;
    cyc({tag, ".if"}, 3'd0, C_IF, 3'd0);
    cyc({tag, ".id"}, 3'd1, C_NO, 3'd0);
    funct = 6'b111111;
    cyc({tag, ".ex"}, 3'd2, C_NO, ea);
    cyc({tag, ".wb"}, 3'd4, C_WB, 3'd0);
    exp_ret++;
    chk({tag, ".retired"}, retired, exp_ret);
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000010; funct = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // under reset: held in IF with only the IF decode visible
    chk("rst.state", {29'd0, state}, 32'd0);
    chk("rst.ctl", {24'd0, ir_we, pc_we, ct_branch, ct_jump, reg_we, mem_re, mem_we, illegal},
        {24'd0, C_IF});
    chk("rst.retired", retired, 32'd0);
    rst = 1'b0;

    do_r("add", 6'b100000, 3'd0);
    do_r("sub", 6'b100010, 3'd1);
    do_r("and", 6'b100100, 3'd2);
    do_r("or",  6'b100101, 3'd3);
    do_r("slt", 6'b101010, 3'd4);

    // addi
    opcode = 6'b001000; funct = 6'b010101;
    cyc("addi.if", 3'd0, C_IF, 3'd0);
    cyc("addi.id", 3'd1, C_NO, 3'd0);
    cyc("addi.ex", 3'd2, C_NO, 3'd0);
    cyc("addi.wb", 3'd4, C_WB, 3'd0);
    exp_ret++;

    // beq taken and not taken: pc_we is not gated by alu_zero
    opcode = 6'b000100; alu_zero = 1'b1;
    cyc("beq1.if", 3'd0, C_IF, 3'd0);
    cyc("beq1.id", 3'd1, C_NO, 3'd0);
    cyc("beq1.ex", 3'd2, C_BEQ, 3'd1);
    alu_zero = 1'b0;
    cyc("beq0.if", 3'd0, C_IF, 3'd0);
    cyc("beq0.id", 3'd1, C_NO, 3'd0);
    cyc("beq0.ex", 3'd2, C_BEQ, 3'd1);
    exp_ret += 2;
    chk("beq.retired", retired, exp_ret);

    // jump
    opcode = 6'b000010;
    cyc("j.if", 3'd0, C_IF, 3'd0);
    cyc("j.id", 3'd1, C_J, 3'd0);
    exp_ret++;
    chk("j.retired", retired, exp_ret);

    // lw with memory not ready
    opcode = 6'b100011; mem_ready = 1'b0;
    cyc("lw.if", 3'd0, C_IF, 3'd0);
    cyc("lw.id", 3'd1, C_NO, 3'd0);
    cyc("lw.ex", 3'd2, C_NO, 3'd0);
`ifdef MEM_WAIT_EN
    cyc("lw.mem0", 3'd3, C_LWM, 3'd0);
    cyc("lw.mem1", 3'd3, C_LWM, 3'd0);
    cyc("lw.mem2", 3'd3, C_LWM, 3'd0);
    mem_ready = 1'b1;
`endif
    cyc("lw.mem", 3'd3, C_LWM, 3'd0);
    mem_ready = 1'b0;
    cyc("lw.wb", 3'd4, C_WB, 3'd0);
    exp_ret++;

    // sw
    opcode = 6'b101011;
    cyc("sw.if", 3'd0, C_IF, 3'd0);
    cyc("sw.id", 3'd1, C_NO, 3'd0);
    cyc("sw.ex", 3'd2, C_NO, 3'd0);
`ifdef MEM_WAIT_EN
    cyc("sw.memw", 3'd3, C_SWW, 3'd0);
    mem_ready = 1'b1;
`endif
    cyc("sw.mem", 3'd3, C_SWF, 3'd0);
    mem_ready = 1'b0;
    exp_ret++;
    chk("sw.state_after", {29'd0, state}, 32'd0);

    // undecoded opcode, then undecoded R-type funct
    opcode = 6'b111111;
    cyc("illop.if", 3'd0, C_IF, 3'd0);
    cyc("illop.id", 3'd1, C_ILL, 3'd0);
    opcode = 6'b000000; funct = 6'b111111;
    cyc("illfn.if", 3'd0, C_IF, 3'd0);
    cyc("illfn.id", 3'd1, C_ILL, 3'd0);
    exp_ret += 2;
    chk("ill.retired", retired, exp_ret);
    chk("ill.state_after", {29'd0, state}, 32'd0);

    // retired wraps from all-ones to zero
    opcode = 6'b000010;
    force dut.retired_q = 32'hFFFF_FFFF;
    cyc("wrap.if", 3'd0, C_IF, 3'd0);
    release dut.retired_q;
    chk("wrap.pre", retired, 32'hFFFF_FFFF);
    cyc("wrap.id", 3'd1, C_J, 3'd0);
    exp_ret = 32'd0;
    chk("wrap.retired", retired, exp_ret);

    // reset during sw MEM aborts without a write or retirement
    opcode = 6'b101011; mem_ready = 1'b0;
    cyc("swr.if", 3'd0, C_IF, 3'd0);
    cyc("swr.id", 3'd1, C_NO, 3'd0);
    cyc("swr.ex", 3'd2, C_NO, 3'd0);
`ifdef MEM_WAIT_EN
    chk("swr.mem_ctl", {24'd0, ir_we, pc_we, ct_branch, ct_jump, reg_we, mem_re, mem_we, illegal},
        {24'd0, C_SWW});
`else
    chk("swr.mem_ctl", {24'd0, ir_we, pc_we, ct_branch, ct_jump, reg_we, mem_re, mem_we, illegal},
        {24'd0, C_SWF});
`endif
    rst = 1'b1;
    #1;
    chk("swr.state", {29'd0, state}, 32'd0);
    chk("swr.mem_we", {31'd0, mem_we}, 32'd0);
    chk("swr.pc_we", {31'd0, pc_we}, 32'd0);
    chk("swr.retired", retired, exp_ret);
    @(negedge clk);
    chk("swr.hold_state", {29'd0, state}, 32'd0);
    chk("swr.hold_retired", retired, exp_ret);
    opcode = 6'b000010;
    rst = 1'b0;
    cyc("post.if", 3'd0, C_IF, 3'd0);
    cyc("post.id", 3'd1, C_J, 3'd0);
    exp_ret++;
    chk("post.retired", retired, exp_ret);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
